// File: rtl/gtfmac_tx_pattern_gen.sv
// TX AXI-stream frame generator for the GTF MAC: emits a 16-bit sequence pattern
// (skipping the checker's idle/fill words) in framed bursts with configurable gaps.
module gtfmac_tx_pattern_gen #(
    parameter int          MAX_FRAME_BEATS = 256,
    parameter int          GAP_W           = 8,
    parameter logic [15:0] SEED            = 16'h0001
) (
    input  logic             tx_clk,
    input  logic             tx_rst,
    input  logic             gen_enable,
    input  logic             gen_restart,
    input  logic [15:0]      frame_beats,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [31:0]      frame_limit,
    input  logic             tx_axis_tready,
    input  logic             tx_axis_tcan_start,
    output logic             tx_axis_tvalid,
    output logic [63:0]      tx_axis_tdata,
    output logic [7:0]       tx_axis_tlast,
    output logic [1:0]       tx_axis_tsof,
    output logic             gen_busy,
    output logic             gen_done,
    output logic [31:0]      frames_sent,
    output logic [31:0]      words_sent
);

    localparam logic [15:0] MAX_B = 16'(MAX_FRAME_BEATS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_GAP, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [15:0]      pat;
    logic [15:0]      beats_cfg, beats_left, beats_clamped;
    logic [GAP_W-1:0] gap_cfg, gap_cnt;
    logic             accept, last_beat, frame_end, limit_hit;

    function automatic logic [15:0] pattern_next(input logic [15:0] cur);
        logic [15:0] n;
        n = cur + 16'd1;
        // The two skipped words are far apart, so one extra step always lands on a legal value
        if (n == 16'hDF1C || n == 16'h2144)
            n = n + 16'd1;
        return n;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        beats_clamped = frame_beats;
        if (frame_beats == 16'd0)
            beats_clamped = 16'd1;
        else if (frame_beats > MAX_B)
            beats_clamped = MAX_B;
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (gen_restart) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:
                    if (gen_enable) state_nxt = S_WAIT_START;
                S_WAIT_START, S_DATA: begin
                    if (frame_end) begin
                        if (limit_hit)              state_nxt = S_DONE;
                        else if (!gen_enable)       state_nxt = S_IDLE;
                        else if (gap_cfg == '0)     state_nxt = S_WAIT_START;
                        else                        state_nxt = S_GAP;
                    end else if (tx_axis_tvalid) begin
                        state_nxt = S_DATA;
                    end
                end
                S_GAP: begin
                    if (!gen_enable)                state_nxt = S_IDLE;
                    else if (gap_cnt == GAP_W'(1))  state_nxt = S_WAIT_START;
                end
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // tvalid rises combinationally with tcan_start so the first beat leaves in that same cycle
    always_comb begin
        tx_axis_tvalid = (state == S_DATA) || (state == S_WAIT_START && tx_axis_tcan_start);
        accept         = tx_axis_tvalid && tx_axis_tready;
        last_beat      = (beats_left == 16'd1);
        frame_end      = accept && last_beat;
        limit_hit      = (frame_limit != 32'd0) && (frames_sent + 32'd1 == frame_limit);
        tx_axis_tdata  = tx_axis_tvalid ? {4{pat}} : 64'd0;
        tx_axis_tlast  = (tx_axis_tvalid && last_beat) ? 8'h80 : 8'h00;
        tx_axis_tsof   = (tx_axis_tvalid && beats_left == beats_cfg) ? 2'b01 : 2'b00;
        gen_busy       = (state != S_IDLE) && (state != S_DONE);
        gen_done       = (state == S_DONE);
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            pat         <= SEED;
            frames_sent <= 32'd0;
            words_sent  <= 32'd0;
        end else if (gen_restart) begin
            pat         <= SEED;
            frames_sent <= 32'd0;
            words_sent  <= 32'd0;
        end else if (accept) begin
            pat        <= pattern_next(pat);
            words_sent <= sat_inc(words_sent);
            if (last_beat)
                frames_sent <= sat_inc(frames_sent);
        end
    end

    // Frame geometry is only meaningful once WAIT_START has been entered, so it carries no reset
    always_ff @(posedge tx_clk) begin
        if (state == S_IDLE) begin
            beats_cfg <= beats_clamped;
            gap_cfg   <= gap_cycles;
        end
        if (state_nxt == S_WAIT_START)
            beats_left <= (state == S_IDLE) ? beats_clamped : beats_cfg;
        else if (accept)
            beats_left <= beats_left - 16'd1;
        if (state != S_GAP && state_nxt == S_GAP)
            gap_cnt <= gap_cfg;
        else if (state == S_GAP)
            gap_cnt <= gap_cnt - GAP_W'(1);
    end

endmodule

// File: tb/tb_gtfmac_tx_pattern_gen.sv
// Bench for gtfmac_tx_pattern_gen: four instances with different seeds share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_gtfmac_tx_pattern_gen;

    localparam int NI = 4;

    logic        tx_clk = 1'b0;
    logic        rst, en, restart, rdy, can;
    logic [15:0] fb;
    logic [7:0]  gap;
    logic [31:0] limit;

    logic        tvalid [NI];
    logic [63:0] tdata  [NI];
    logic [7:0]  tlast  [NI];
    logic [1:0]  tsof   [NI];
    logic        busy   [NI];
    logic        done   [NI];
    logic [31:0] frames [NI];
    logic [31:0] words  [NI];

    always #5 tx_clk = ~tx_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [15:0] S = (g == 0) ? 16'h0001 : (g == 1) ? 16'hDF1A :
                                    (g == 2) ? 16'h2142 : 16'hFFFE;
        gtfmac_tx_pattern_gen #(.MAX_FRAME_BEATS(256), .GAP_W(8), .SEED(S)) u_dut (
            .tx_clk            (tx_clk),
            .tx_rst            (rst),
            .gen_enable        (en),
            .gen_restart       (restart),
            .frame_beats       (fb),
            .gap_cycles        (gap),
            .frame_limit       (limit),
            .tx_axis_tready    (rdy),
            .tx_axis_tcan_start(can),
            .tx_axis_tvalid    (tvalid[g]),
            .tx_axis_tdata     (tdata[g]),
            .tx_axis_tlast     (tlast[g]),
            .tx_axis_tsof      (tsof[g]),
            .gen_busy          (busy[g]),
            .gen_done          (done[g]),
            .frames_sent       (frames[g]),
            .words_sent        (words[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_ARMED, P_SENDING, P_PAUSE, P_FINISHED} phase_t;

    logic [15:0] seeds [NI];
    phase_t      m_phase;
    int          m_pat [NI];
    int          m_left, m_cfg_beats, m_cfg_gap, m_gap_left;
    bit          m_first;
    longint      m_frames, m_words;
    logic [15:0] dut_q [NI][$];

    function automatic int advance(input int x);
        int y;
        y = (x + 1) % 65536;
        while (y == 'hDF1C || y == 'h2144) y = (y + 1) % 65536;
        return y;
    endfunction

    function automatic longint sat(input longint x);
        return (x >= 64'hFFFF_FFFF) ? x : x + 1;
    endfunction

    function automatic int clamp_beats(input int b);
        if (b == 0) return 1;
        if (b > 256) return 256;
        return b;
    endfunction

    function automatic bit exp_valid();
        return (m_phase == P_ARMED && can) || m_phase == P_SENDING;
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_frames = 0;
        m_words  = 0;
        for (int i = 0; i < NI; i++) m_pat[i] = int'(seeds[i]);
    endtask

    task automatic arm_frame();
        m_phase = P_ARMED;
        m_left  = m_cfg_beats;
        m_first = 1'b1;
    endtask

    task automatic model_step();
        bit v;
        v = exp_valid();
        if (restart) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: if (en) begin
                m_cfg_beats = clamp_beats(int'(fb));
                m_cfg_gap   = int'(gap);
                arm_frame();
            end
            P_ARMED, P_SENDING: if (v) begin
                if (rdy) begin
                    m_words = sat(m_words);
                    for (int i = 0; i < NI; i++) m_pat[i] = advance(m_pat[i]);
                    m_first = 1'b0;
                    if (m_left == 1) begin
                        if (limit != 0 && m_frames + 1 == longint'(limit)) m_phase = P_FINISHED;
                        else if (!en)                                  m_phase = P_IDLE;
                        else if (m_cfg_gap == 0)                       arm_frame();
                        else begin m_phase = P_PAUSE; m_gap_left = m_cfg_gap; end
                        m_frames = sat(m_frames);
                    end else begin
                        m_left--;
                        m_phase = P_SENDING;
                    end
                end else begin
                    m_phase = P_SENDING;
                end
            end
            P_PAUSE: begin
                if (!en) m_phase = P_IDLE;
                else if (m_gap_left == 1) arm_frame();
                else m_gap_left--;
            end
            default: ;
        endcase
    endtask

    task automatic compare_outputs();
        bit v, b;
        v = exp_valid();
        b = (m_phase == P_ARMED || m_phase == P_SENDING || m_phase == P_PAUSE);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("tvalid[%0d]", i), 64'(tvalid[i]), 64'(v));
            check($sformatf("tdata[%0d]", i), tdata[i], v ? {4{m_pat[i][15:0]}} : 64'd0);
            check($sformatf("tsof[%0d]", i), 64'(tsof[i]), (v && m_first) ? 64'd1 : 64'd0);
            check($sformatf("tlast[%0d]", i), 64'(tlast[i]), (v && m_left == 1) ? 64'h80 : 64'd0);
            check($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(b));
            check($sformatf("done[%0d]", i), 64'(done[i]), 64'(m_phase == P_FINISHED));
            check($sformatf("frames[%0d]", i), 64'(frames[i]), 64'(m_frames));
            check($sformatf("words[%0d]", i), 64'(words[i]), 64'(m_words));
            if (tvalid[i] && rdy) dut_q[i].push_back(tdata[i][15:0]);
        end
    endtask

    // Entered at posedge+1 with inputs applied; returns at the next posedge+1
    task automatic tick();
        #4;
        compare_outputs();
        model_step();
        @(posedge tx_clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic start_run(input int beats, input int g, input int lim);
        fb      = 16'(beats);
        gap     = 8'(g);
        limit   = 32'(lim);
        restart = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) dut_q[i].delete();
    endtask

    task automatic check_seq(input string tag, input int idx, input logic [15:0] e [4]);
        check({tag, "_len"}, 64'(dut_q[idx].size() >= 4), 64'd1);
        for (int k = 0; k < 4 && k < dut_q[idx].size(); k++)
            check($sformatf("%s_%0d", tag, k), 64'(dut_q[idx][k]), 64'(e[k]));
    endtask

    initial begin
        logic [15:0] e0 [4], e1 [4], e2 [4], e3 [4];
        int sizes [12];
        seeds   = '{16'h0001, 16'hDF1A, 16'h2142, 16'hFFFE};
        sizes   = '{0, 1, 2, 3, 4, 5, 7, 8, 255, 256, 257, 300};
        rst     = 1'b1;
        en      = 1'b0;
        restart = 1'b0;
        rdy     = 1'b0;
        can     = 1'b0;
        fb      = 16'd4;
        gap     = 8'd0;
        limit   = 32'd0;
        model_reset();
        @(posedge tx_clk);
        #1;
        compare_outputs();
        @(posedge tx_clk);
        #1;
        rst = 1'b0;

        // Basic single frame; the four seeds cover plain, both skip words and wrap
        en = 1'b1; rdy = 1'b1; can = 1'b1;
        start_run(4, 2, 1);
        for (int c = 0; c < 12; c++) tick();
        e0 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        e1 = '{16'hDF1A, 16'hDF1B, 16'hDF1D, 16'hDF1E};
        e2 = '{16'h2142, 16'h2143, 16'h2145, 16'h2146};
        e3 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        check_seq("basic", 0, e0);
        check_seq("skip_df1c", 1, e1);
        check_seq("skip_2144", 2, e2);
        check_seq("wrap", 3, e3);
        check("basic_frames", 64'(frames[0]), 64'd1);
        check("basic_words", 64'(words[0]), 64'd4);
        check("basic_done", 64'(done[0]), 64'd1);

        // Backpressure 1,0,0,1: accepted words must be contiguous with no repeats
        start_run(6, 1, 2);
        for (int c = 0; c < 60; c++) begin
            rdy = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        check("bp_words", 64'(words[0]), 64'd12);
        check("bp_count", 64'(dut_q[0].size()), 64'd12);
        for (int k = 0; k < dut_q[0].size(); k++)
            check($sformatf("bp_seq_%0d", k), 64'(dut_q[0][k]), 64'(k + 1));

        // tcan_start gating, then tcan_start dropped mid-frame
        rdy = 1'b1; can = 1'b0;
        start_run(5, 0, 1);
        for (int c = 0; c < 10; c++) tick();
        check("gate_words", 64'(words[0]), 64'd0);
        check("gate_busy", 64'(busy[0]), 64'd1);
        can = 1'b1;
        tick();
        can = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("gate_frames", 64'(frames[0]), 64'd1);
        check("gate_done", 64'(done[0]), 64'd1);

        // Continuous 1-beat frames, then stop
        can = 1'b1;
        start_run(1, 0, 0);
        for (int c = 0; c < 20; c++) tick();
        en = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("cont_frames_eq_words", 64'(frames[0]), 64'(words[0]));
        check("cont_idle", 64'(busy[0] | tvalid[0]), 64'd0);
        en = 1'b1;

        // Restart mid-frame, then async reset mid-frame
        start_run(20, 0, 0);
        for (int c = 0; c < 8; c++) tick();
        restart = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) tick();
        check("pre_rst_valid", 64'(tvalid[0]), 64'(exp_valid()));
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_tvalid[%0d]", i), 64'(tvalid[i]), 64'd0);
            check($sformatf("arst_tdata[%0d]", i), tdata[i], 64'd0);
            check($sformatf("arst_tsof[%0d]", i), 64'(tsof[i]), 64'd0);
            check($sformatf("arst_words[%0d]", i), 64'(words[i]), 64'd0);
            check($sformatf("arst_busy[%0d]", i), 64'(busy[i]), 64'd0);
        end
        model_reset();
        @(posedge tx_clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            int p_rdy, p_can, ncyc, beats;
            beats = sizes[$urandom_range(0, 11)];
            p_rdy = $urandom_range(30, 100);
            p_can = $urandom_range(20, 100);
            ncyc  = (beats > 100) ? 320 : 150;
            en    = 1'b1;
            start_run(beats, $urandom_range(0, 3), $urandom_range(0, 4));
            for (int c = 0; c < ncyc; c++) begin
                rdy = ($urandom_range(0, 99) < p_rdy);
                can = ($urandom_range(0, 99) < p_can);
                if ($urandom_range(0, 99) < 3) en = ~en;
                if ($urandom_range(0, 299) == 0) restart = 1'b1;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gtfmac_tx_pattern_gen.md
Name: gtfmac_tx_pattern_gen

Overview:
- Frame generator that drives the TX AXI-stream of the GTF MAC with a deterministic 16-bit sequence pattern.
- The TX/RX data-stream FIFO checker captures this pattern on both the TX and RX sides and compares them.
- tdata[15:0] of every accepted data beat carries the next value of a 16-bit counter. Values 16'hDF1C and 16'h2144 are skipped, because the checker drops those words as idle/fill.
- Sits in the tx_clk domain between the register interface and the MAC TX port.

Parameters:
- MAX_FRAME_BEATS, 256, upper clamp on frame length in 8-byte beats.
- GAP_W, 8, width of inter-frame gap counter.
- SEED, 16'h0001, counter value loaded at reset/restart.

Ports:
- tx_clk  in  1  TX user clock; all logic in this domain.
- tx_rst  in  1  asynchronous active-high reset.
- gen_enable  in  1  level; 1 = run, 0 = stop after current frame.
- gen_restart  in  1  one-cycle pulse; reloads counter to SEED, clears status, returns to IDLE.
- frame_beats  in  16  beats per frame; 0 treated as 1, values >MAX_FRAME_BEATS clamped.
- gap_cycles  in  GAP_W  idle cycles between frames.
- frame_limit  in  32  frames to send; 0 = continuous.
- tx_axis_tready  in  1  MAC ready.
- tx_axis_tcan_start  in  1  MAC permits a new frame to start this cycle.
- tx_axis_tvalid  out  1  beat valid.
- tx_axis_tdata  out  64  {4 copies of pattern word}.
- tx_axis_tlast  out  8  8'h80 on last beat of frame, else 0.
- tx_axis_tsof  out  2  2'b01 on first beat of frame, else 0.
- gen_busy  out  1  high in any state other than IDLE/DONE.
- gen_done  out  1  high in DONE.
- frames_sent  out  32  completed frames (last beat accepted).
- words_sent  out  32  accepted beats.

Behaviour:
- Reset (async assert, sync deassert by user): state IDLE, all outputs 0, counter = SEED.
- Beat acceptance: a beat is accepted on tvalid & tready.
  - While tvalid=1 and tready=0, tdata/tlast/tsof are held stable and tvalid stays 1.
- FSM states: IDLE, WAIT_START, DATA, GAP, DONE.
  - IDLE: gen_enable=1 -> WAIT_START (latch frame_beats/gap_cycles into internal registers).
  - WAIT_START: when tcan_start=1, assert tvalid with tsof=2'b01 in the same cycle -> DATA.
  - DATA: on each accepted beat, decrement beat_remaining and advance the pattern.
    - Last beat carries tlast=8'h80.
    - A 1-beat frame carries both tsof=01 and tlast=80.
    - Acceptance of the last beat increments frames_sent and leaves DATA:
      - -> DONE if frame_limit!=0 and frames_sent+1==frame_limit;
      - -> IDLE if gen_enable=0;
      - else -> GAP (or -> WAIT_START directly if gap_cycles=0).
  - GAP: tvalid=0; count gap_cycles cycles, then -> WAIT_START. A gen_enable drop in GAP -> IDLE.
  - DONE: holds until gen_restart.
- tvalid is never asserted outside WAIT_START/DATA.
  - In WAIT_START, tvalid stays 0 until tcan_start is seen.
  - tcan_start is ignored mid-frame.
- Pattern advance: next = cur+1 mod 2^16.
  - If next equals DF1C or 2144, it is incremented again.
  - DF1C and 2144 are non-adjacent, so a single extra step suffices.
  - Wrap FFFF -> 0000 is legal.
- words_sent increments per accepted beat.
- Both status counters saturate at 32'hFFFFFFFF.
- gen_enable deassert mid-frame: the frame completes normally (no truncation), then -> IDLE.
- gen_restart in any state:
  - next cycle: state IDLE, tvalid=0, counter=SEED, frames_sent=words_sent=0;
  - a mid-frame restart truncates the frame without tlast (intended for test-abort only).
- gen_restart and gen_enable together: restart takes priority; IDLE is left on the following cycle.
- Latency: tvalid is asserted in the first WAIT_START cycle with tcan_start=1.
  - WAIT_START is entered one cycle after gen_enable rises in IDLE.

Test Plan:
- Basic frame: SEED=1, frame_beats=4, gap=2, limit=1, tready=tcan_start=1, enable=1.
  - Expect 4 beats with tdata[15:0]=1,2,3,4; tsof=01 on beat 1; tlast=80 on beat 4.
  - Then DONE; frames_sent=1, words_sent=4.
- Skip values: SEED=16'hDF1A, 4 beats.
  - Expect DF1A, DF1B, DF1D, DF1E.
  - Repeat with SEED=16'h2142: expect 2142, 2143, 2145, 2146.
- Backpressure: tready toggles 1,0,0,1 during DATA.
  - tdata/tlast/tsof stable while stalled; no beat skipped or duplicated; words_sent counts only accepted beats.
- tcan_start gating: tcan_start=0 for 10 cycles after enable.
  - tvalid stays 0 throughout; first beat appears the cycle tcan_start=1.
  - tcan_start deasserted mid-frame has no effect.
- Continuous/stop: limit=0, frame_beats=1, gap=0.
  - Back-to-back frames, each beat with tsof=01 and tlast=80.
  - Drop enable mid-run: the current frame finishes, then IDLE with tvalid=0.
- Restart/reset: gen_restart pulse mid-frame -> next cycle tvalid=0, counters 0, pattern reloads SEED.
  - Async tx_rst mid-frame -> outputs 0 immediately, without waiting for a clock edge.
  - Wrap check: SEED=FFFE gives FFFE, FFFF, 0000.
